// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath.
package rc4_pkg;

  localparam int DEFAULT_MSG_LENGTH = 32;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'd0,
    ST_INIT  = 5'd1,
    ST_INC_I = 5'd2,
    ST_RD_SI = 5'd3,
    ST_WT_SI = 5'd4,
    ST_LT_SI = 5'd5,
    ST_RD_SJ = 5'd6,
    ST_WT_SJ = 5'd7,
    ST_LT_SJ = 5'd8,
    ST_WR_SI = 5'd9,
    ST_WR_SJ = 5'd10,
    ST_RD_F  = 5'd11,
    ST_WT_F  = 5'd12,
    ST_LT_F  = 5'd13,
    ST_WR_D  = 5'd14,
    ST_NEXT  = 5'd15,
    ST_DONE  = 5'd16
  } rc4_dec_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Legal plaintext character test: lowercase a-z or space.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_legal
);

  assign is_legal = ((data >= CHAR_LO) && (data <= CHAR_HI)) || (data == CHAR_SPACE);

endmodule

// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA + XOR decrypt stage; S is swapped in place, plaintext checked per byte.
// Optional RC4_EARLY_ABORT_EN: stop at the first illegal plaintext byte.
module rc4_decrypt_fsm
  import rc4_pkg::*;
#(
  parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  output logic [7:0]     s_address,
  output logic [7:0]     s_data,
  output logic           s_wren,
  input  logic [7:0]     s_q,
  output logic [7:0]     enc_address,
  input  logic [7:0]     enc_q,
  output logic [7:0]     dec_address,
  output logic [7:0]     dec_data,
  output logic           dec_wren,
  output logic           done,
  output logic           key_valid,
  output rc4_dec_state_t dbg_state
);

  localparam logic [8:0] LAST_K = 9'(MSG_LENGTH - 1);

  rc4_dec_state_t state;
  logic [7:0] i, j, si, sj, f, enc_byte;
  logic [8:0] k;
  logic       valid;
  logic [7:0] plain;
  logic       byte_legal;

  assign plain     = f ^ enc_byte;
  assign dbg_state = state;

  rc4_char_check u_char_check (
    .data     (plain),
    .is_legal (byte_legal)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= ST_IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      f        <= '0;
      enc_byte <= '0;
      k        <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_INIT;
        ST_INIT: begin
          i     <= '0;
          j     <= '0;
          k     <= '0;
          valid <= 1'b1;
          state <= ST_INC_I;
        end
        ST_INC_I: begin
          i     <= i + 8'd1;
          state <= ST_RD_SI;
        end
        ST_RD_SI: state <= ST_WT_SI;
        ST_WT_SI: state <= ST_LT_SI;
        ST_LT_SI: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= ST_RD_SJ;
        end
        ST_RD_SJ: state <= ST_WT_SJ;
        ST_WT_SJ: state <= ST_LT_SJ;
        ST_LT_SJ: begin
          sj    <= s_q;
          state <= ST_WR_SI;
        end
        ST_WR_SI: state <= ST_WR_SJ;
        ST_WR_SJ: state <= ST_RD_F;
        ST_RD_F:  state <= ST_WT_F;
        ST_WT_F:  state <= ST_LT_F;
        ST_LT_F: begin
          f        <= s_q;
          enc_byte <= enc_q;
          state    <= ST_WR_D;
        end
        ST_WR_D: begin
          if (!byte_legal) valid <= 1'b0;
`ifdef RC4_EARLY_ABORT_EN
          state <= byte_legal ? ST_NEXT : ST_DONE;
`else
          state <= ST_NEXT;
`endif
        end
        ST_NEXT: begin
          if (k == LAST_K) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 9'd1;
            state <= ST_INC_I;
          end
        end
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory ports decoded purely from state and registers; s_q/enc_q never reach an output.
  always_comb begin
    s_address   = '0;
    s_data      = '0;
    s_wren      = 1'b0;
    enc_address = '0;
    dec_address = '0;
    dec_data    = '0;
    dec_wren    = 1'b0;
    case (state)
      ST_RD_SI, ST_WT_SI: s_address = i;
      ST_RD_SJ, ST_WT_SJ: s_address = j;
      ST_WR_SI: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      ST_WR_SJ: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      ST_RD_F, ST_WT_F: begin
        s_address   = si + sj;
        enc_address = k[7:0];
      end
      ST_WR_D: begin
        dec_address = k[7:0];
        dec_data    = plain;
        dec_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign done      = (state == ST_DONE);
  assign key_valid = done & valid;

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Directed bench: two DUTs (MSG_LENGTH 9 and 1) share one set of memory models via a select mux.
module tb_rc4_decrypt_fsm;
  import rc4_pkg::*;

`ifdef RC4_EARLY_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic sel     = 1'b0;

  logic [7:0] s_q, enc_q;
  logic [7:0] a_s_address, a_s_data, a_enc_address, a_dec_address, a_dec_data;
  logic       a_s_wren, a_dec_wren, a_done, a_key_valid;
  logic [7:0] b_s_address, b_s_data, b_enc_address, b_dec_address, b_dec_data;
  logic       b_s_wren, b_dec_wren, b_done, b_key_valid;
  rc4_dec_state_t a_state, b_state;

  rc4_decrypt_fsm #(.MSG_LENGTH(9)) dut_a (
    .CLOCK_50(clk), .reset(reset), .start(start_a),
    .s_address(a_s_address), .s_data(a_s_data), .s_wren(a_s_wren), .s_q(s_q),
    .enc_address(a_enc_address), .enc_q(enc_q),
    .dec_address(a_dec_address), .dec_data(a_dec_data), .dec_wren(a_dec_wren),
    .done(a_done), .key_valid(a_key_valid), .dbg_state(a_state)
  );

  rc4_decrypt_fsm #(.MSG_LENGTH(1)) dut_b (
    .CLOCK_50(clk), .reset(reset), .start(start_b),
    .s_address(b_s_address), .s_data(b_s_data), .s_wren(b_s_wren), .s_q(s_q),
    .enc_address(b_enc_address), .enc_q(enc_q),
    .dec_address(b_dec_address), .dec_data(b_dec_data), .dec_wren(b_dec_wren),
    .done(b_done), .key_valid(b_key_valid), .dbg_state(b_state)
  );

  logic [7:0] m_s_address, m_s_data, m_enc_address, m_dec_address, m_dec_data;
  logic       m_s_wren, m_dec_wren;
  assign m_s_address   = sel ? b_s_address   : a_s_address;
  assign m_s_data      = sel ? b_s_data      : a_s_data;
  assign m_s_wren      = sel ? b_s_wren      : a_s_wren;
  assign m_enc_address = sel ? b_enc_address : a_enc_address;
  assign m_dec_address = sel ? b_dec_address : a_dec_address;
  assign m_dec_data    = sel ? b_dec_data    : a_dec_data;
  assign m_dec_wren    = sel ? b_dec_wren    : a_dec_wren;

  // memory models: one-cycle synchronous read
  logic [7:0] s_mem   [256];
  logic [7:0] enc_mem [256];
  logic [7:0] dec_mem [256];
  logic [7:0] s_ref   [256];

  always @(posedge clk) begin
    s_q   <= s_mem[m_s_address];
    enc_q <= enc_mem[m_enc_address];
    if (m_s_wren)   s_mem[m_s_address]     <= m_s_data;
    if (m_dec_wren) dec_mem[m_dec_address] <= m_dec_data;
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic load_ksa();
    logic [7:0] key [3];
    logic [7:0] jj, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int x = 0; x < 256; x++) s_ref[x] = 8'(x);
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + s_ref[x] + key[x % 3];
      t = s_ref[x]; s_ref[x] = s_ref[jj]; s_ref[jj] = t;
    end
    for (int x = 0; x < 256; x++) s_mem[x] <= s_ref[x];
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) begin
      s_ref[x] = 8'(x);
      s_mem[x] <= 8'(x);
    end
  endtask

  task automatic load_rom(input logic [7:0] first);
    logic [71:0] rom;
    rom = 72'hBB_F3_16_E8_D9_40_AF_0A_D3;
    for (int x = 0; x < 256; x++) enc_mem[x] <= 8'h00;
    for (int x = 0; x < 9; x++) enc_mem[x] <= rom[71 - 8*x -: 8];
    enc_mem[0] <= first;
  endtask

  task automatic clear_dec();
    for (int x = 0; x < 256; x++) dec_mem[x] <= 8'h00;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  // Cycle 0 is the IDLE cycle with start high; sampled at each negedge.
  task automatic run(input bit use_b, input int pulse_cyc, input int reset_cyc,
                     output int done_cyc, output int wren_cnt);
    int cyc;
    @(negedge clk);
    sel = use_b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    cyc = 0; done_cyc = -1; wren_cnt = 0;
    while (cyc < 1000 && done_cyc < 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (use_b ? b_dec_wren : a_dec_wren) wren_cnt++;
      if (use_b ? b_done : a_done) done_cyc = cyc;
      start_a = 1'b0;
      start_b = 1'b0;
      if (cyc == pulse_cyc) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == reset_cyc) begin
        reset = 1'b1;
        break;
      end
    end
  endtask

  task automatic prga_ref(input int n);
    logic [7:0] ii, jj, t;
    ii = 8'd0; jj = 8'd0;
    for (int x = 0; x < n; x++) begin
      ii = ii + 8'd1;
      jj = jj + s_ref[ii];
      t = s_ref[ii]; s_ref[ii] = s_ref[jj]; s_ref[jj] = t;
    end
  endtask

  function automatic logic [7:0] chr(input logic [71:0] str, input int idx);
    return str[71 - 8*idx -: 8];
  endfunction

  int done_cyc, wren_cnt;
  logic [71:0] txt_upper, txt_lower;

  initial begin
    txt_upper = "Plaintext";
    txt_lower = "plaintext";
    clear_dec();
    load_identity();
    load_rom(8'hBB);
    repeat (3) @(negedge clk);
    check_eq("rst_a_state", 32'(a_state), 32'(ST_IDLE));
    check_eq("rst_a_done", 32'(a_done), 32'd0);
    check_eq("rst_a_key_valid", 32'(a_key_valid), 32'd0);
    check_eq("rst_a_s_wren", 32'(a_s_wren), 32'd0);
    check_eq("rst_a_dec_wren", 32'(a_dec_wren), 32'd0);
    check_eq("rst_a_s_address", 32'(a_s_address), 32'd0);
    check_eq("rst_a_dec_data", 32'(a_dec_data), 32'd0);
    check_eq("rst_b_done", 32'(b_done), 32'd0);
    reset = 1'b0;

    // "Plaintext": 'P' is illegal
    load_ksa();
    load_rom(8'hBB);
    clear_dec();
    run(1'b0, -1, -1, done_cyc, wren_cnt);
    check_eq("t1_done_cyc", 32'(done_cyc), ABORT ? 32'd15 : 32'd128);
    check_eq("t1_wren_cnt", 32'(wren_cnt), ABORT ? 32'd1 : 32'd9);
    check_eq("t1_key_valid", 32'(a_key_valid), 32'd0);
    for (int x = 0; x < 9; x++)
      check_eq($sformatf("t1_ram%0d", x), 32'(dec_mem[x]),
               (ABORT && x > 0) ? 32'd0 : 32'(chr(txt_upper, x)));
    pulse_reset();

    // "plaintext" with a stray start during byte 3
    load_ksa();
    load_rom(8'h9B);
    clear_dec();
    run(1'b0, 47, -1, done_cyc, wren_cnt);
    check_eq("t2_done_cyc", 32'(done_cyc), 32'd128);
    check_eq("t2_wren_cnt", 32'(wren_cnt), 32'd9);
    check_eq("t2_key_valid", 32'(a_key_valid), 32'd1);
    for (int x = 0; x < 9; x++)
      check_eq($sformatf("t2_ram%0d", x), 32'(dec_mem[x]), 32'(chr(txt_lower, x)));
    @(negedge clk);
    check_eq("t2_done_held", 32'(a_done), 32'd1);
    prga_ref(9);
    for (int x = 0; x < 256; x++) exp_q.push_back(32'(s_ref[x]));
    for (int x = 0; x < 256; x++)
      check_eq($sformatf("t2_s%0d", x), 32'(s_mem[x]), exp_q.pop_front());
    pulse_reset();

    // identity S, one byte: self-swap at address 1, f = S[2] = 2
    load_identity();
    load_rom(8'h00);
    clear_dec();
    run(1'b1, -1, -1, done_cyc, wren_cnt);
    check_eq("t3_done_cyc", 32'(done_cyc), ABORT ? 32'd15 : 32'd16);
    check_eq("t3_wren_cnt", 32'(wren_cnt), 32'd1);
    check_eq("t3_ram0", 32'(dec_mem[0]), 32'h02);
    check_eq("t3_key_valid", 32'(b_key_valid), 32'd0);
    check_eq("t3_s1", 32'(s_mem[1]), 32'd1);
    check_eq("t3_s2", 32'(s_mem[2]), 32'd2);
    pulse_reset();

    // identity S, nine bytes: first byte illegal
    load_identity();
    load_rom(8'h00);
    clear_dec();
    run(1'b0, -1, -1, done_cyc, wren_cnt);
    check_eq("t4_done_cyc", 32'(done_cyc), ABORT ? 32'd15 : 32'd128);
    check_eq("t4_wren_cnt", 32'(wren_cnt), ABORT ? 32'd1 : 32'd9);
    check_eq("t4_key_valid", 32'(a_key_valid), 32'd0);
    check_eq("t4_ram0", 32'(dec_mem[0]), 32'h02);
    pulse_reset();

    // reset in cycle 20, then a clean rerun
    load_ksa();
    load_rom(8'h9B);
    clear_dec();
    run(1'b0, -1, 20, done_cyc, wren_cnt);
    @(negedge clk);
    check_eq("t5_state", 32'(a_state), 32'(ST_IDLE));
    check_eq("t5_s_wren", 32'(a_s_wren), 32'd0);
    check_eq("t5_dec_wren", 32'(a_dec_wren), 32'd0);
    check_eq("t5_done", 32'(a_done), 32'd0);
    reset = 1'b0;
    load_ksa();
    clear_dec();
    run(1'b0, -1, -1, done_cyc, wren_cnt);
    check_eq("t5_done_cyc", 32'(done_cyc), 32'd128);
    check_eq("t5_key_valid", 32'(a_key_valid), 32'd1);
    for (int x = 0; x < 9; x++)
      check_eq($sformatf("t5_ram%0d", x), 32'(dec_mem[x]), 32'(chr(txt_lower, x)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
